// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle for uart_tx.
// The master side supplies bytes and parity type; the slave side (uart_tx)
// drives the serial line and the busy flag.
interface uart_tx_if;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// stop bit. Each bit lasts PRESCALE clock cycles (legal 1..32).
// Optional feature macro: UART_TX_PARITY_EN (adds the parity slot; PAR_TYP
// selects even (0) or odd (1) parity). Without it the frame is 10 bits and
// PAR_TYP has no effect.
// TX_OUT and Busy are registered from the next-state values, so the first
// start-bit cycle follows the accept edge directly and Busy drops on the edge
// that re-enters IDLE, leaving exactly one idle-high cycle between frames.
module uart_tx #(
  parameter int PRESCALE = 8
) (
  input  logic    CLK,
  input  logic    RST,
  uart_tx_if.slave bus
);

  localparam int CNT_W = $clog2(PRESCALE) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,ST_PARITY = 3'd4
`endif
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity is the XOR of the byte; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`endif

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [2:0]       idx_r, idx_next_s;
  logic [7:0]       data_r, data_next_s;
  logic             tx_out_r, tx_next_s;
  logic             busy_r, busy_next_s;
  logic             bit_done_s;
`ifdef UART_TX_PARITY_EN
  logic             par_typ_r, par_typ_next_s;
`endif

  // With PRESCALE=1 the counter never leaves zero, so every cycle ends a bit.
  assign bit_done_s = (cnt_r == CNT_MAX);

  // State, counters, latched byte and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      idx_r     <= 3'd0;
      data_r    <= 8'h00;
      tx_out_r  <= 1'b1;
      busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_typ_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      idx_r     <= idx_next_s;
      data_r    <= data_next_s;
      tx_out_r  <= tx_next_s;
      busy_r    <= busy_next_s;
`ifdef UART_TX_PARITY_EN
      par_typ_r <= par_typ_next_s;
`endif
    end
  end

  // Next-state, bit sequencing and next output values.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    idx_next_s     = idx_r;
    data_next_s    = data_r;
`ifdef UART_TX_PARITY_EN
    par_typ_next_s = par_typ_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (bus.Data_Valid && !busy_r) begin
          state_next_s   = ST_START;
          data_next_s    = bus.P_DATA;
          cnt_next_s     = '0;
          idx_next_s     = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_typ_next_s = bus.PAR_TYP;
`endif
        end else begin
          cnt_next_s = '0;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_next_s = ST_DATA;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          cnt_next_s = '0;
          if (idx_r == 3'd7) begin
            idx_next_s = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            idx_next_s = idx_r + 3'd1;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          state_next_s = ST_STOP;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
        idx_next_s   = 3'd0;
      end
    endcase

    case (state_next_s)
      ST_IDLE:   tx_next_s = 1'b1;
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = data_next_s[idx_next_s];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next_s = parity_bit(data_next_s, par_typ_next_s);
`endif
      ST_STOP:   tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase

    busy_next_s = (state_next_s != ST_IDLE);
  end

  assign bus.TX_OUT = tx_out_r;
  assign bus.Busy   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one instance with PRESCALE=4 and one with
// PRESCALE=1. Expected serial waveforms come from a frame-level model
// (bit list of the frame, each bit repeated PRESCALE cycles).
module tb_uart_tx;

  localparam int P4 = 4;
  localparam int P1 = 1;

  logic CLK;
  logic RST;

  uart_tx_if b4 ();
  uart_tx_if b1 ();

  uart_tx #(.PRESCALE(P4)) dut4 (.CLK(CLK), .RST(RST), .bus(b4.slave));
  uart_tx #(.PRESCALE(P1)) dut1 (.CLK(CLK), .RST(RST), .bus(b1.slave));

  int n_checks = 0;
  int n_errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count every comparison and report mismatches.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: list of serial bits and its length.
  function automatic void model_frame(input logic [7:0] d, input logic pt,
                                      output logic [10:0] bits, output int n);
    bits = 11'h7FF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = (^d) ^ pt;
    n = 11;
`else
    n = 10;
`endif
    bits[n - 1] = 1'b1;
  endfunction

  function automatic logic cur_tx(input bit s);
    return s ? b1.TX_OUT : b4.TX_OUT;
  endfunction

  function automatic logic cur_busy(input bit s);
    return s ? b1.Busy : b4.Busy;
  endfunction

  function automatic int pre(input bit s);
    return s ? P1 : P4;
  endfunction

  task automatic drive(input bit s, input logic v, input logic [7:0] d, input logic pt);
    if (s) begin
      b1.Data_Valid = v; b1.P_DATA = d; b1.PAR_TYP = pt;
    end else begin
      b4.Data_Valid = v; b4.P_DATA = d; b4.PAR_TYP = pt;
    end
  endtask

  task automatic wait_idle(input bit s);
    int k = 0;
    while (cur_busy(s) === 1'b1 && k < 400) begin
      @(posedge CLK); #1;
      k++;
    end
    if (k >= 400) check_eq("wait_idle_timeout", 32'(k), 32'd0);
  endtask

  // Called #1 after the accept edge; checks every cycle of the frame.
  // Optionally re-drives the inputs (valid held high) partway through.
  task automatic check_frame(input bit s, input logic [7:0] d, input logic pt,
                             input bit chg, input logic [7:0] chg_d, input logic chg_pt,
                             input string tag);
    logic [10:0] bits;
    int n;
    int p = pre(s);
    model_frame(d, pt, bits, n);
    for (int c = 0; c < n * p; c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
      end
      if (chg && c == 2 * p) drive(s, 1'b1, chg_d, chg_pt);
      check_eq($sformatf("%s_tx_c%0d", tag, c), 32'(cur_tx(s)), 32'(bits[c / p]));
      check_eq($sformatf("%s_busy_c%0d", tag, c), 32'(cur_busy(s)), 32'd1);
    end
  endtask

  task automatic check_idle(input bit s, input string tag);
    check_eq({tag, "_idle_tx"}, 32'(cur_tx(s)), 32'd1);
    check_eq({tag, "_idle_busy"}, 32'(cur_busy(s)), 32'd0);
  endtask

  // Full single transfer: accept, scramble inputs, check frame and idle.
  task automatic send(input bit s, input logic [7:0] d, input logic pt, input string tag);
    wait_idle(s);
    @(negedge CLK);
    drive(s, 1'b1, d, pt);
    @(posedge CLK); #1;
    drive(s, 1'b0, 8'($urandom), 1'($urandom));
    check_frame(s, d, pt, 1'b0, 8'h00, 1'b0, tag);
    @(posedge CLK); #1;
    check_idle(s, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic pt;

    // Reset held low while inputs toggle.
    RST = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      drive(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
      drive(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
      @(posedge CLK); #1;
      check_idle(1'b0, $sformatf("rst_hold%0d", i));
      check_idle(1'b1, $sformatf("rst_hold1_%0d", i));
    end
    @(negedge CLK);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check_idle(1'b0, $sformatf("post_rst%0d", i));
    end

    // Directed parity cases.
    send(1'b0, 8'hA5, 1'b0, "a5_even");
    send(1'b0, 8'hA5, 1'b1, "a5_odd");
    send(1'b0, 8'h00, 1'b1, "00_odd");

    // Randomized bytes and parity types.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      pt = 1'($urandom);
      send(1'b0, d, pt, $sformatf("rnd%0d", i));
    end

    // Back-to-back with Data_Valid held and P_DATA changed mid-frame.
    wait_idle(1'b0);
    @(negedge CLK);
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    @(posedge CLK); #1;
    check_frame(1'b0, 8'h5A, 1'b0, 1'b1, 8'h3C, 1'b1, "b2b_first");
    @(posedge CLK); #1;
    check_idle(1'b0, "b2b_gap");
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 8'hFF, 1'b0);
    check_frame(1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, "b2b_second");
    @(posedge CLK); #1;
    check_idle(1'b0, "b2b_end");

    // Reset asserted during data bit 3.
    wait_idle(1'b0);
    @(negedge CLK);
    drive(1'b0, 1'b1, 8'hF7, 1'b0);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat ((1 + 3) * P4 + 1) @(posedge CLK);
    #1;
    check_eq("midrst_bit3", 32'(b4.TX_OUT), 32'd0);
    check_eq("midrst_busy_before", 32'(b4.Busy), 32'd1);
    #1 RST = 1'b0;
    #1;
    check_idle(1'b0, "midrst_now");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check_idle(1'b0, $sformatf("midrst_hold%0d", i));
    end
    @(negedge CLK);
    RST = 1'b1;
    send(1'b0, 8'h81, 1'b0, "after_rst_81");

    // PRESCALE=1 instance.
    send(1'b1, 8'hFF, 1'b0, "p1_ff_pt0");
    send(1'b1, 8'hFF, 1'b1, "p1_ff_pt1");
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      pt = 1'($urandom);
      send(1'b1, d, pt, $sformatf("p1_rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts one parallel byte per handshake and shifts it onto a single serial line as start bit, 8 data bits LSB first, optional parity bit, and stop bit. It is the transmit-side counterpart of the UART RX path, using the same frame format and the same parity convention. Each bit is held for PRESCALE clock cycles. Downstream logic observes only TX_OUT. Upstream logic paces bytes with Busy.

## Interface
- PRESCALE, default 8: clock cycles per serial bit. Legal range is 1 to 32. The internal prescale counter is $clog2(PRESCALE)+1 bits wide.
- CLK  input  1  single clock; all state updates on its rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  8  byte to transmit; sampled only on the accept cycle
- Data_Valid  input  1  request to send P_DATA
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on the accept cycle
- TX_OUT  output  1  serial line; idles high
- Busy  output  1  high while a frame is in progress

## Operation
- Accept condition: Data_Valid=1 and Busy=0 at a rising edge of CLK.
  - On accept, P_DATA and PAR_TYP are latched into internal registers.
  - The parity bit is computed from the latched byte: even = XOR of the 8 bits; odd = inverted XOR.
- Data_Valid while Busy=1 is ignored. The byte is dropped; there is no queue.
- Changes on P_DATA or PAR_TYP after the accept cycle do not affect the frame in flight.
- FSM states and transitions:
  - IDLE: TX_OUT=1, Busy=0. Moves to START on accept.
  - START: TX_OUT=0. Moves to DATA after PRESCALE cycles.
  - DATA: TX_OUT = data[bit_idx], bit_idx 0..7. bit_idx advances every PRESCALE cycles. After bit 7 completes, moves to PARITY if the feature is compiled in, otherwise to STOP.
  - PARITY: TX_OUT = parity bit, held for PRESCALE cycles, then moves to STOP.
  - STOP: TX_OUT=1, held for PRESCALE cycles, then moves to IDLE.
- TX_OUT and Busy are registered outputs; they are not decoded combinationally from state.
- Reset values: TX_OUT=1, Busy=0, state=IDLE, bit_idx=0, prescale counter=0, data register=8'h00.
- Reset asserted mid-frame: the frame is aborted asynchronously and TX_OUT returns to 1 with no glitch low. After reset release, the next accepted byte starts a fresh frame.

## Timing
- Let A be the accept edge.
  - First start-bit cycle: edge A+1, where TX_OUT=0 and Busy=1.
  - Data bit n occupies edges A+1+(n+1)*PRESCALE through A+(n+2)*PRESCALE.
- Frame length, counted from A+1 to the last stop cycle inclusive:
  - 11*PRESCALE cycles with parity.
  - 10*PRESCALE cycles without parity.
- Busy stays 1 for the entire frame, including the last stop cycle, and falls at the edge where IDLE is entered.
- Back-to-back transfers:
  - In the first IDLE cycle Busy=0, so a byte can be accepted there.
  - The next start bit then begins one cycle later.
  - Minimum frame-to-frame period is frame length + 1 cycle, with exactly one extra high cycle on TX_OUT.
- PRESCALE=1 is legal: each bit lasts one cycle, and the prescale counter is effectively bypassed.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is present. The frame is 11 bits and PAR_TYP selects even or odd parity.
  - Undefined: the PARITY state and parity logic are removed. The frame is 10 bits, DATA goes directly to STOP, and PAR_TYP is accepted but has no effect.
- The port list is identical in both builds.

## Test plan
- Reset: hold RST=0 and toggle inputs. TX_OUT must stay 1 and Busy 0 throughout, and also after release with Data_Valid=0.
- Even parity, PRESCALE=4, macro defined: send 8'hA5 with PAR_TYP=0. Serial sequence must be 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles long (parity=0). Busy must be high for exactly 44 cycles.
- Odd parity: send 8'hA5 with PAR_TYP=1. The parity slot must be 1, with everything else as in the even-parity case. Then send 8'h00 with PAR_TYP=1; parity must be 1.
- Back-to-back and drop: hold Data_Valid=1 continuously with P_DATA changing to 8'h3C mid-frame.
  - The current frame must be unaffected.
  - The second frame must carry 8'h3C and start exactly 1 idle-high cycle after the first stop bit ends.
- Reset mid-frame: assert RST during data bit 3. TX_OUT must go to 1 and Busy to 0 immediately. After release, 8'h81 must then be transmitted correctly.
- Macro undefined, PRESCALE=1: send 8'hFF. Expected sequence is 0,1,1,1,1,1,1,1,1,1 with Busy high for 10 cycles, and there must be no parity slot regardless of PAR_TYP.
